program_loader_mem: RTL and testbench

Instruction-memory stage directly upstream of the 8-bit CPU core. It holds the program in a 256 x 8 array that is loaded byte-serially over a valid/ready stream. Once loaded, it drives the CPU's `instruction` input from the CPU's `next_addr` fetch address. It also holds the CPU in reset while idle or loading, and flags a fetch past the end of the loaded program.

---
 rtl/program_loader_mem.sv | 113 +++++++++++
 tb/tb_program_loader_mem.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader_mem.sv
// Instruction memory for the 8-bit CPU: byte-serial program load over a valid/ready
// stream, then zero-latency combinational fetch while the CPU is released from reset.
module program_loader_mem #(
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] HOLD_INSN = 8'h40
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] instruction_o,
  output logic              cpu_rst_o,
  output logic [ADDR_W:0]   prog_len_o,
  output logic              halted_o,
  output logic [ADDR_W:0]   wr_ptr_o
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     tgt_len_q, tgt_len_d;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic                cpu_rst_q;
  logic                mem_we;
  logic                last_byte;
  logic                fetch_in_range;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign last_byte = (wr_ptr_q == (tgt_len_q - 1'b1));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    tgt_len_d  = tgt_len_q;
    prog_len_d = prog_len_q;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        if (load_start_i && (load_len_i != '0)) begin
          state_d   = StLoad;
          tgt_len_d = load_len_i;
          wr_ptr_d  = '0;
        end
      end
      StLoad: begin
        // load_ready is high throughout LOAD, so valid alone marks a transfer.
        if (load_valid_i) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (last_byte) begin
            prog_len_d = tgt_len_q;
            state_d    = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      tgt_len_q  <= '0;
      prog_len_q <= '0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      tgt_len_q  <= tgt_len_d;
      prog_len_q <= prog_len_d;
      // Registered copy of (state != RUN) so the CPU reset never glitches.
      cpu_rst_q  <= (state_d != StRun);
    end
  end

  // Array is deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= load_data_i;
    end
  end

  assign fetch_in_range = ({1'b0, fetch_addr_i} < prog_len_q);

  always_comb begin
    instruction_o = HOLD_INSN;
    halted_o      = 1'b0;
    if (state_q == StRun) begin
      halted_o = !fetch_in_range;
      if (fetch_in_range) begin
        instruction_o = mem_q[fetch_addr_i];
      end
    end
  end

  assign load_ready_o = (state_q == StLoad);
  assign cpu_rst_o    = cpu_rst_q;
  assign prog_len_o   = prog_len_q;
  assign wr_ptr_o     = wr_ptr_q;

endmodule

// File: tb/tb_program_loader_mem.sv
// Randomized bench for program_loader_mem against a mode/counter level reference model.
module tb_program_loader_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic [8:0] load_len;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] fetch_addr;
  logic [7:0] instruction;
  logic       cpu_rst;
  logic [8:0] prog_len;
  logic       halted;
  logic [8:0] wr_ptr;

  always #5 clk = ~clk;

  program_loader_mem dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .load_start_i  (load_start),
    .load_len_i    (load_len),
    .load_valid_i  (load_valid),
    .load_data_i   (load_data),
    .load_ready_o  (load_ready),
    .fetch_addr_i  (fetch_addr),
    .instruction_o (instruction),
    .cpu_rst_o     (cpu_rst),
    .prog_len_o    (prog_len),
    .halted_o      (halted),
    .wr_ptr_o      (wr_ptr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: operating mode, bytes accepted, target and loaded lengths.
  localparam int MIdle = 0, MLoad = 1, MRun = 2;
  int         m_mode = MIdle;
  int         m_cnt  = 0;
  int         m_tgt  = 0;
  int         m_plen = 0;
  logic [7:0] m_mem [256];
  logic [7:0] pbytes [256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_check();
    bit         run;
    logic [7:0] exp_instr;
    run = (m_mode == MRun);
    exp_instr = (run && int'(fetch_addr) < m_plen) ? m_mem[fetch_addr] : 8'h40;
    check_eq("ready",    32'(load_ready), 32'(m_mode == MLoad));
    check_eq("cpu_rst",  32'(cpu_rst),    32'(!run));
    check_eq("prog_len", 32'(prog_len),   m_plen);
    check_eq("wr_ptr",   32'(wr_ptr),     m_cnt);
    check_eq("halted",   32'(halted),     32'(run && int'(fetch_addr) >= m_plen));
    check_eq("instr",    32'(instruction), 32'(exp_instr));
  endtask

  task automatic model_step();
    if (reset) begin
      m_mode = MIdle;
      m_cnt  = 0;
      m_plen = 0;
    end else if (m_mode == MLoad) begin
      if (load_valid) begin
        m_mem[m_cnt % 256] = load_data;
        m_cnt++;
        if (m_cnt == m_tgt) begin
          m_plen = m_tgt;
          m_mode = MRun;
        end
      end
    end else if (load_start && load_len != 0) begin
      m_mode = MLoad;
      m_tgt  = int'(load_len);
      m_cnt  = 0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    reset      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = 9'(len);
    tick();
    load_start = 1'b0;
    load_len   = '0;
  endtask

  // Stream pbytes until the model leaves LOAD; abort_at>0 resets after that many bytes.
  task automatic stream(input int valid_pct, input int abort_at);
    int guard = 0;
    while (m_mode == MLoad && guard < 4000) begin
      if (abort_at > 0 && m_cnt == abort_at) begin
        load_valid = 1'b0;
        do_reset();
        return;
      end
      load_valid = ($urandom_range(99) < valid_pct);
      load_data  = load_valid ? pbytes[m_cnt % 256] : 8'($urandom);
      load_start = ($urandom_range(9) == 0);
      load_len   = 9'($urandom_range(256));
      fetch_addr = 8'($urandom);
      tick();
      guard++;
    end
    idle_inputs();
    if (guard >= 4000) check_eq("stream_bound", 1, 0);
  endtask

  task automatic run_fetches(input int n, input int max_addr);
    for (int i = 0; i < n; i++) begin
      fetch_addr = 8'($urandom_range(max_addr));
      tick();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    fetch_addr = '0;
    do_reset();
    do_reset();
    check_eq("rst_cpu_rst", 32'(cpu_rst), 1);
    check_eq("rst_instr", 32'(instruction), 32'h40);
    check_eq("rst_ready", 32'(load_ready), 0);
    check_eq("rst_prog_len", 32'(prog_len), 0);

    // Three-byte load with valid held high.
    pbytes[0] = 8'h05; pbytes[1] = 8'h41; pbytes[2] = 8'h81;
    start_load(3);
    for (int i = 0; i < 3; i++) begin
      check_eq("ready_in_load", 32'(load_ready), 1);
      load_valid = 1'b1;
      load_data  = pbytes[i];
      tick();
    end
    load_valid = 1'b0;
    check_eq("run_cpu_rst", 32'(cpu_rst), 0);
    check_eq("run_prog_len", 32'(prog_len), 3);
    check_eq("run_ready", 32'(load_ready), 0);
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 8'(i);
      #1;
      check_eq("fetch_byte", 32'(instruction), 32'(pbytes[i]));
    end
    fetch_addr = 8'd3;   #1;
    check_eq("oob3_instr", 32'(instruction), 32'h40);
    check_eq("oob3_halted", 32'(halted), 1);
    fetch_addr = 8'd200; #1;
    check_eq("oob200_halted", 32'(halted), 1);
    fetch_addr = 8'd2;   #1;
    check_eq("last_halted", 32'(halted), 0);
    check_eq("last_instr", 32'(instruction), 32'h81);
    tick();

    // Reload from RUN with valid toggling 1,0,0,1,0,1.
    start_load(3);
    check_eq("reload_cpu_rst", 32'(cpu_rst), 1);
    begin
      logic [5:0] pat;
      int         exp_wp [6];
      int         k;
      pat = 6'b101001;
      exp_wp = '{1, 1, 1, 2, 2, 3};
      k = 0;
      for (int i = 0; i < 6; i++) begin
        load_valid = pat[i];
        load_data  = pat[i] ? pbytes[k] : 8'hEE;
        if (pat[i]) k++;
        tick();
        check_eq("gap_wr_ptr", 32'(wr_ptr), exp_wp[i]);
      end
    end
    load_valid = 1'b0;
    check_eq("gap_run_cpu_rst", 32'(cpu_rst), 0);
    run_fetches(6, 5);

    // Reset after 2 of 4 bytes, then a one-byte load.
    for (int i = 0; i < 4; i++) pbytes[i] = 8'($urandom);
    start_load(4);
    stream(100, 2);
    fetch_addr = 8'd0; #1;
    check_eq("abort_cpu_rst", 32'(cpu_rst), 1);
    check_eq("abort_prog_len", 32'(prog_len), 0);
    check_eq("abort_instr", 32'(instruction), 32'h40);
    pbytes[0] = 8'h3C;
    start_load(1);
    stream(100, 0);
    fetch_addr = 8'd0; #1;
    check_eq("one_prog_len", 32'(prog_len), 1);
    check_eq("one_instr", 32'(instruction), 32'h3C);
    run_fetches(4, 3);

    // Full 256-byte program.
    for (int i = 0; i < 256; i++) pbytes[i] = 8'(i);
    start_load(256);
    stream(100, 0);
    check_eq("full_prog_len", 32'(prog_len), 256);
    fetch_addr = 8'd255; #1;
    check_eq("full_255", 32'(instruction), 32'hFF);
    for (int i = 0; i < 20; i++) begin
      fetch_addr = 8'($urandom);
      #1;
      check_eq("full_no_halt", 32'(halted), 0);
      tick();
    end
    do_reset();
    start_load(0);
    tick();
    check_eq("len0_ready", 32'(load_ready), 0);
    check_eq("len0_cpu_rst", 32'(cpu_rst), 1);

    // Reload of 2 bytes from RUN: HOLD_INSN throughout the reload.
    for (int i = 0; i < 3; i++) pbytes[i] = 8'($urandom);
    start_load(3);
    stream(100, 0);
    pbytes[0] = 8'hA5; pbytes[1] = 8'h5A;
    fetch_addr = 8'd0;
    start_load(2);
    check_eq("r2_cpu_rst", 32'(cpu_rst), 1);
    check_eq("r2_hold", 32'(instruction), 32'h40);
    stream(50, 0);
    check_eq("r2_prog_len", 32'(prog_len), 2);
    fetch_addr = 8'd1; #1;
    check_eq("r2_instr", 32'(instruction), 32'h5A);

    // Randomized loads, stalls, spurious starts, aborts and fetches.
    for (int it = 0; it < 30; it++) begin
      int len;
      len = ($urandom_range(7) == 0) ? 256 : int'($urandom_range(1, 40));
      for (int i = 0; i < 256; i++) pbytes[i] = 8'($urandom);
      start_load(len);
      stream(int'($urandom_range(30, 100)),
             ($urandom_range(5) == 0 && len > 1) ? int'($urandom_range(1, len - 1)) : 0);
      run_fetches(10, (len + 5 > 255) ? 255 : len + 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
